bp_ctr_table: RTL

//  Multi-read-port saturating-counter table for the branch predictor (bimodal/PHT storage).

---
 rtl/bp_ctr_pkg.sv | 29 ++
 rtl/bp_ctr_table_sat.sv | 20 ++
 rtl/bp_ctr_table.sv | 111 +++++++++++
 3 files changed

// File: rtl/bp_ctr_pkg.sv
// Shared types for the branch-predictor counter table.
// Struct widths track the default INDEX/CTR_W of bp_ctr_table.
package bp_ctr_pkg;

  localparam int BP_INDEX = 10;
  localparam int BP_CTR_W = 2;

  typedef logic [BP_CTR_W-1:0] ctr_t;

  localparam ctr_t CTR_MAX = '1;

  typedef enum logic {
    BP_INIT,
    BP_READY
  } bp_fsm_t;

  typedef struct packed {
    logic                valid;
    logic [BP_INDEX-1:0] addr;
    logic                taken;
  } upd_s1_t;

  typedef struct packed {
    logic                valid;
    logic [BP_INDEX-1:0] addr;
    ctr_t                new_ctr;
  } upd_s2_t;

endpackage

// File: rtl/bp_ctr_table_sat.sv
// Saturating increment/decrement of one predictor counter.
module bp_ctr_sat #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] i_ctr,
  input  logic             i_taken,
  output logic [CTR_W-1:0] o_ctr
);

  localparam logic [CTR_W-1:0] MAX = '1;

  always_comb begin
    o_ctr = i_ctr;
    if (i_taken && i_ctr != MAX)
      o_ctr = i_ctr + CTR_W'(1);
    else if (!i_taken && i_ctr != '0)
      o_ctr = i_ctr - CTR_W'(1);
  end

endmodule

// File: rtl/bp_ctr_table.sv
// Multi-port saturating counter table with init walker and RMW update pipe.
// Define BP_CTR_BYPASS_EN to forward the pending S2 write to the read ports.
module bp_ctr_table
  import bp_ctr_pkg::*;
#(
  parameter int RPORT    = 2,
  parameter int DEPTH    = 1024,
  parameter int INDEX    = BP_INDEX,
  parameter int CTR_W    = BP_CTR_W,
  parameter int INIT_VAL = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RPORT*INDEX-1:0] addr_i,
  output logic [RPORT*CTR_W-1:0] ctr_o,
  output logic [RPORT-1:0]       pred_o,
  input  logic                   upd_valid_i,
  input  logic [INDEX-1:0]       upd_addr_i,
  input  logic                   upd_taken_i,
  output logic                   ready_o
);

  localparam ctr_t INIT_C = ctr_t'(INIT_VAL);

  ctr_t             r_ram [DEPTH];
  bp_fsm_t          r_state;
  bp_fsm_t          w_state_nxt;
  logic [INDEX-1:0] r_init_idx;
  upd_s1_t          r_s1;
  upd_s2_t          r_s2;
  ctr_t             w_old;
  ctr_t             w_new;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= BP_INIT;
      r_init_idx <= '0;
      r_s1       <= '0;
      r_s2       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == BP_INIT)
        r_init_idx <= r_init_idx + INDEX'(1);
      r_s1.valid   <= upd_valid_i && (r_state == BP_READY);
      r_s1.addr    <= upd_addr_i;
      r_s1.taken   <= upd_taken_i;
      r_s2.valid   <= r_s1.valid;
      r_s2.addr    <= r_s1.addr;
      r_s2.new_ctr <= w_new;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      BP_INIT:
        if (r_init_idx == INDEX'(DEPTH-1))
          w_state_nxt = BP_READY;
      BP_READY:
        w_state_nxt = BP_READY;
      default:
        w_state_nxt = BP_INIT;
    endcase
  end

  assign ready_o = (r_state == BP_READY);

  // Back-to-back updates to one index must see the not-yet-written S2 value.
  always_comb begin
    w_old = r_ram[r_s1.addr];
    if (r_s2.valid && r_s2.addr == r_s1.addr)
      w_old = r_s2.new_ctr;
  end

  bp_ctr_sat #(
    .CTR_W (CTR_W)
  ) u_sat (
    .i_ctr   (w_old),
    .i_taken (r_s1.taken),
    .o_ctr   (w_new)
  );

  // Walker and S2 share the single write port; FSM state keeps them apart.
  always_ff @(posedge clk) begin
    if (r_state == BP_INIT)
      r_ram[r_init_idx] <= INIT_C;
    else if (r_s2.valid)
      r_ram[r_s2.addr] <= r_s2.new_ctr;
  end

  for (genvar p = 0; p < RPORT; p++) begin : g_rd
    logic [INDEX-1:0] w_raddr;
    ctr_t             w_rd;

    assign w_raddr = addr_i[p*INDEX +: INDEX];

    always_comb begin
      w_rd = r_ram[w_raddr];
`ifdef BP_CTR_BYPASS_EN
      if (r_s2.valid && r_s2.addr == w_raddr)
        w_rd = r_s2.new_ctr;
`endif
      if (r_state == BP_INIT)
        w_rd = INIT_C;
    end

    assign ctr_o[p*CTR_W +: CTR_W] = w_rd;
    assign pred_o[p]               = w_rd[CTR_W-1];
  end

endmodule
